// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the CPU/VGA data-RAM arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, CPU_RD, VGA_RD} owner_t;
  localparam int STREAK_W = 4;
endpackage

// File: rtl/vga_cpu_mem_arbiter.sv
// vga_cpu_mem_arbiter: VGA-priority single-port RAM arbiter with CPU starvation guard
module vga_cpu_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int VGA_MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam logic [STREAK_W-1:0] max_streak = STREAK_W'(VGA_MAX_STREAK);
  logic [STREAK_W-1:0] streak;
  owner_t owner;
  logic gnt_cpu, gnt_vga;
  always_comb begin
    gnt_cpu = cpu_req & (~vga_req | (streak == max_streak));
    gnt_vga = vga_req & ~gnt_cpu;
    cpu_stall = cpu_req & ~gnt_cpu;
    mem_addr = gnt_cpu ? cpu_addr : gnt_vga ? vga_addr : '0;
    mem_we = gnt_cpu & cpu_we & ~rst;
    mem_wdata = gnt_cpu ? cpu_wdata : '0;
  end
  // Streak only counts VGA wins that actually made the CPU wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
      owner <= IDLE;
    end else begin
      streak <= (gnt_cpu || !cpu_req) ? '0 : (gnt_vga && streak < max_streak) ? streak + 1'b1 : streak;
      owner <= (gnt_cpu && !cpu_we) ? CPU_RD : gnt_vga ? VGA_RD : IDLE;
    end
  end
  assign cpu_rvalid = (owner == CPU_RD);
  assign vga_rvalid = (owner == VGA_RD);
  assign cpu_rdata = mem_rdata;
  assign vga_rdata = mem_rdata;
endmodule

// File: tb/tb_vga_cpu_mem_arbiter.sv
// tb_vga_cpu_mem_arbiter: scoreboard bench with a behavioural 1-cycle RAM and arbitration model
module tb_vga_cpu_mem_arbiter;
  localparam int MAX = 4;
  logic clk = 0, rst = 1;
  logic cpu_req = 1, cpu_we = 0, vga_req = 1;
  logic [15:0] cpu_addr = 16'h0020, vga_addr = 16'h0200, mem_addr;
  logic [31:0] cpu_wdata = '0, cpu_rdata, vga_rdata, mem_wdata, mem_rdata;
  logic cpu_stall, cpu_rvalid, vga_rvalid, mem_we;
  logic [31:0] ram [0:65535];
  logic [31:0] ref_mem [0:65535];
  typedef struct {logic [31:0] data; int due;} exp_t;
  exp_t cpu_q[$], vga_q[$];
  int checks = 0, failures = 0, cyc = 0, m_streak = 0, waitc = 0;
  int cpu_rv_total = 0, vga_rv_total = 0, gnt_at = -1;
  logic last_gc, dut_gc;
  logic [31:0] last_cpu = '0;

  vga_cpu_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .VGA_MAX_STREAK(MAX)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  function automatic logic [31:0] pat(input logic [15:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (cpu_rvalid === 1'b1) cpu_rv_total++;
    if (vga_rvalid === 1'b1) vga_rv_total++;
    if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
      chk("cpu_rvalid", {31'b0, cpu_rvalid}, 1);
      chk("cpu_rdata", cpu_rdata, cpu_q[0].data);
      last_cpu = cpu_rdata;
      void'(cpu_q.pop_front());
    end else chk("cpu_rvalid_idle", {31'b0, cpu_rvalid}, 0);
    if (vga_q.size() > 0 && vga_q[0].due == cyc) begin
      chk("vga_rvalid", {31'b0, vga_rvalid}, 1);
      chk("vga_rdata", vga_rdata, vga_q[0].data);
      void'(vga_q.pop_front());
    end else chk("vga_rvalid_idle", {31'b0, vga_rvalid}, 0);
  end

  task automatic step();
    logic gc, gv;
    @(negedge clk);
    gc = cpu_req & (~vga_req | (m_streak == MAX));
    gv = vga_req & ~gc;
    chk("cpu_stall", {31'b0, cpu_stall}, {31'b0, cpu_req & ~gc});
    chk("mem_we", {31'b0, mem_we}, {31'b0, gc & cpu_we & ~rst});
    if ((gc | gv) && !rst) chk("mem_addr", {16'b0, mem_addr}, {16'b0, gc ? cpu_addr : vga_addr});
    if (gc && cpu_we && !rst) chk("mem_wdata", mem_wdata, cpu_wdata);
    dut_gc = cpu_req & ~cpu_stall;
    if (cpu_req && cpu_stall) waitc++;
    else if (cpu_req) begin
      chk("cpu_wait_bound", {31'b0, waitc <= MAX}, 1);
      waitc = 0;
    end
    if (!rst) begin
      if (gc && !cpu_we) cpu_q.push_back('{ref_mem[cpu_addr], cyc + 1});
      if (gc && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
      if (gv) vga_q.push_back('{ref_mem[vga_addr], cyc + 1});
    end
    if (rst) waitc = 0;
    last_gc = gc;
    m_streak = (rst || gc || !cpu_req) ? 0 : gv ? m_streak + 1 : m_streak;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cpu0, vga0;
    for (int i = 0; i < 65536; i++) begin
      ram[i] = pat(16'(i));
      ref_mem[i] = pat(16'(i));
    end
    step();
    step();
    rst = 0;
    for (int k = 0; k < 20; k++) begin
      vga_addr = 16'h0200 + 16'(k);
      step();
      if (k == 0) chk("first_after_rst_stall", {31'b0, cpu_stall}, 1);
      if (dut_gc && gnt_at < 0) gnt_at = k;
      if (last_gc) cpu_req = 0;
    end
    chk("cpu_gnt_cycle", gnt_at, 4);
    vga_req = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 32'hDEADBEEF;
    cpu0 = cpu_rv_total;
    step();
    cpu_we = 0;
    step();
    cpu_req = 0;
    step();
    step();
    chk("write_read_data", last_cpu, 32'hDEADBEEF);
    chk("write_read_rvalid_cnt", cpu_rv_total - cpu0, 1);
    vga0 = vga_rv_total;
    for (int i = 0; i < 8; i++) begin
      vga_req = 1;
      vga_addr = 16'h0100 + 16'(i);
      step();
    end
    vga_req = 0;
    step();
    step();
    chk("vga_stream_cnt", vga_rv_total - vga0, 8);
    cpu0 = cpu_rv_total;
    rst = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    step();
    rst = 0; cpu_req = 0;
    step();
    step();
    chk("rst_drop_rvalid_cnt", cpu_rv_total - cpu0, 0);
    for (int n = 0; n < 10000; n++) begin
      if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req = 1;
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 16'($urandom_range(0, 15));
        cpu_wdata = $urandom;
      end
      vga_req = 1'($urandom_range(0, 1));
      vga_addr = 16'h8000 | 16'($urandom_range(0, 255));
      step();
      if (last_gc) cpu_req = 0;
    end
    cpu_req = 0; vga_req = 0;
    step();
    step();
    chk("cpu_q_drained", cpu_q.size(), 0);
    chk("vga_q_drained", vga_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_cpu_mem_arbiter.md
Name: vga_cpu_mem_arbiter

Overview:
Arbitrates one single-port synchronous data RAM (altsyncram-style, 1-cycle registered read) between the RSA ASIP core's load/store port and the VGA pixel fetch unit.
- VGA has priority so scanout never tears.
- A streak counter guarantees the CPU forward progress while VGA is busy.
- Sits between the core, the VGA controller and the data memory inside rsa_asip_system.

Parameters:
ADDR_W, 16, RAM word-address width
DATA_W, 32, RAM data width
VGA_MAX_STREAK, 4, max consecutive VGA grants while CPU is waiting (range 1-15)

Ports:
clk  in  1  system clock (single clock domain)
rst  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request, held until granted
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_stall  out  1  CPU request pending but not granted this cycle
cpu_rdata  out  DATA_W  read data returned to CPU
cpu_rvalid  out  1  cpu_rdata valid (one cycle after a CPU read grant)
vga_req  in  1  VGA read request
vga_addr  in  ADDR_W  VGA word address
vga_rdata  out  DATA_W  read data returned to VGA
vga_rvalid  out  1  vga_rdata valid (one cycle after a VGA grant)
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data (valid one cycle after address)

Behaviour:
- Grant (combinational, one per cycle):
  - gnt_cpu = cpu_req & (~vga_req | streak == VGA_MAX_STREAK).
  - gnt_vga = vga_req & ~gnt_cpu.
- RAM mux:
  - gnt_cpu: mem_addr = cpu_addr, mem_we = cpu_we, mem_wdata = cpu_wdata.
  - gnt_vga: mem_addr = vga_addr, mem_we = 0.
  - No grant: mem_addr = 0, mem_we = 0.
  - mem_we is forced to 0 while rst = 1.
- cpu_stall = cpu_req & ~gnt_cpu (combinational, same cycle).
- Streak counter, 4 bits, registered:
  - Cleared on rst, on gnt_cpu, or when cpu_req = 0.
  - Increments on a gnt_vga cycle with cpu_req = 1.
  - Never exceeds VGA_MAX_STREAK.
- Read-return owner register, states IDLE / CPU_RD / VGA_RD, updated each clock:
  - CPU_RD on a gnt_cpu read.
  - VGA_RD on gnt_vga.
  - IDLE otherwise, including CPU writes.
- Data return:
  - cpu_rvalid = (owner == CPU_RD) and vga_rvalid = (owner == VGA_RD); both registered, so read latency is exactly 1 cycle after grant.
  - cpu_rdata and vga_rdata both wire to mem_rdata; consumers must qualify with rvalid.
- Back-to-back: one grant per cycle with no bubbles. Sustained throughput is 1 access/cycle.
- Simultaneous requests:
  - VGA wins unless the streak has saturated; then the CPU wins exactly one cycle and the streak clears.
  - A CPU write and a VGA read to the same address in the same cycle cannot both be granted. Ordering follows grant order.
- Reset values: owner = IDLE, streak = 0, cpu_rvalid = 0, vga_rvalid = 0, mem_we = 0.
- Reset mid-operation: an in-flight read is dropped and no rvalid is produced in the cycle after rst. Requesters must reissue.
- Requester rule: the CPU must hold cpu_req, cpu_we, cpu_addr and cpu_wdata stable while cpu_stall = 1. The arbiter does not latch requests.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum logic [1:0] owner_t {IDLE, CPU_RD, VGA_RD}.
  - Localparam STREAK_W = 4.
- Single module. The streak counter and owner register are small enough to stay inline; no sub-module needed.

Test Plan:
1. rst = 1 for 2 cycles with cpu_req = vga_req = 1 -> mem_we = 0, both rvalid = 0, streak = 0. First cycle after release: VGA granted, cpu_stall = 1.
2. CPU write 0xDEADBEEF to addr 0x0010, vga_req = 0, then CPU read of 0x0010 -> write: mem_we = 1 for one cycle, no rvalid. Read: cpu_rvalid = 1 one cycle after grant, cpu_rdata = 0xDEADBEEF.
3. vga_req held high for 20 cycles, cpu_req high from cycle 0, VGA_MAX_STREAK = 4 -> CPU granted on cycle 4. cpu_stall low only that cycle. VGA regranted on cycle 5.
4. VGA streams addresses 0x0100..0x0107 back-to-back with no CPU traffic -> vga_rvalid high for 8 consecutive cycles, vga_rdata matches RAM contents in order, no bubbles.
5. CPU read granted, then rst asserted on the next edge -> cpu_rvalid stays 0 and owner = IDLE.
6. Randomised cpu_req/vga_req for 10k cycles against a scoreboard -> every CPU request completes within VGA_MAX_STREAK + 1 cycles, and every read returns the reference-model RAM value.
